dvp_capture: RTL and testbench

DVP_CAPTURE -- requirements
Module: dvp_capture

---
 rtl/cam_pkg.sv | 18 +
 rtl/dvp_pixel_pack.sv | 58 +++++
 rtl/dvp_capture.sv | 168 ++++++++++++++++
 tb/tb_dvp_capture.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types and constants for the DVP camera capture path.
package cam_pkg;

  localparam int CNT_W = 12;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_SKIP    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_CAPTURE = 2'd2
  } cap_state_t;

  // Counter increment that sticks at the top value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dvp_pixel_pack.sv
// Beat phase counter and beat-to-pixel packer for the DVP capture path.
module dvp_pixel_pack #(
  parameter int DATA_W    = 8,
  parameter int PIX_BYTES = 2,
  parameter bit BYTE_SWAP = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        active,
  input  logic                        href,
  input  logic [DATA_W-1:0]           data,
  output logic                        phase_nz,
  output logic                        complete,
  output logic [DATA_W*PIX_BYTES-1:0] pixel
);

  logic phase;
  logic last_beat;

  assign last_beat = (PIX_BYTES == 1) ? 1'b1 : phase;
  assign complete  = active & href & last_beat;
  assign phase_nz  = phase;

  // Step the phase on every captured beat, wrap at the pixel end, clear whenever the line is not valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 1'b0;
    end else if (!active || !href || last_beat) begin
      phase <= 1'b0;
    end else begin
      phase <= 1'b1;
    end
  end

  generate
    if (PIX_BYTES == 1) begin : g_single
      assign pixel = data;
    end else begin : g_pair
      logic [DATA_W-1:0] first_beat;

      // Hold the first beat of a pair until its partner arrives.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          first_beat <= '0;
        end else if (active && href && !last_beat) begin
          first_beat <= data;
        end
      end

      if (BYTE_SWAP) begin : g_swap
        assign pixel = {data, first_beat};
      end else begin : g_noswap
        assign pixel = {first_beat, data};
      end
    end
  endgenerate

endmodule

// File: rtl/dvp_capture.sv
// DVP camera capture: frame skipping after reset, crop window, pixel packing and frame bookkeeping.
module dvp_capture
  import cam_pkg::*;
#(
  parameter int               DATA_W     = 8,
  parameter int               PIX_BYTES  = 2,
  parameter bit               BYTE_SWAP  = 1'b0,
  parameter int               FRAME_SKIP = 10,
  parameter logic [CNT_W-1:0] H_START    = 12'd0,
  parameter logic [CNT_W-1:0] H_SIZE     = 12'd640,
  parameter logic [CNT_W-1:0] V_START    = 12'd0,
  parameter logic [CNT_W-1:0] V_SIZE     = 12'd480
) (
  input  logic                        ov5640_pclk,
  input  logic                        sys_rst_n,
  input  logic                        cap_en,
  input  logic                        ov5640_vsync,
  input  logic                        ov5640_href,
  input  logic [DATA_W-1:0]           ov5640_data,
  output logic                        ov5640_wr_en,
  output logic [DATA_W*PIX_BYTES-1:0] ov5640_data_out,
  output logic                        frame_start,
  output logic                        frame_done,
  output logic [15:0]                 frame_cnt,
  output logic                        byte_err
);

  localparam logic [CNT_W:0] H_END = {1'b0, H_START} + {1'b0, H_SIZE};
  localparam logic [CNT_W:0] V_END = {1'b0, V_START} + {1'b0, V_SIZE};

  cap_state_t state, state_next;
  logic vsync_q, href_q;
  logic vs_rise, href_fall;
  logic [15:0] skip_cnt;
  logic start_now, done_now;
  logic [CNT_W-1:0] x, y;
  logic in_capture, in_window, pix_write;
  logic phase_nz, complete;
  logic [DATA_W*PIX_BYTES-1:0] pixel;

  assign vs_rise    = ov5640_vsync & ~vsync_q;
  assign href_fall  = ~ov5640_href & href_q;
  assign in_capture = (state == ST_CAPTURE);
  assign in_window  = (x >= H_START) && ({1'b0, x} < H_END) &&
                      (y >= V_START) && ({1'b0, y} < V_END);
  assign pix_write  = complete && !vs_rise && in_window;

  dvp_pixel_pack #(
    .DATA_W   (DATA_W),
    .PIX_BYTES(PIX_BYTES),
    .BYTE_SWAP(BYTE_SWAP)
  ) u_pack (
    .clk     (ov5640_pclk),
    .rst_n   (sys_rst_n),
    .active  (in_capture),
    .href    (ov5640_href),
    .data    (ov5640_data),
    .phase_nz(phase_nz),
    .complete(complete),
    .pixel   (pixel)
  );

  // Keep the previous vsync/href samples for edge detection.
  always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
    end else begin
      vsync_q <= ov5640_vsync;
      href_q  <= ov5640_href;
    end
  end

  // State register.
  always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= ST_SKIP;
    end else begin
      state <= state_next;
    end
  end

  // Frame-boundary decisions; once the skip count is reached SKIP behaves exactly like IDLE.
  always_comb begin
    state_next = state;
    start_now  = 1'b0;
    done_now   = 1'b0;
    if (vs_rise) begin
      case (state)
        ST_SKIP: begin
          if (skip_cnt == 16'(FRAME_SKIP)) begin
            start_now  = cap_en;
            state_next = cap_en ? ST_CAPTURE : ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (cap_en) begin
            start_now  = 1'b1;
            state_next = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          done_now = 1'b1;
          if (cap_en) begin
            start_now = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_SKIP;
      endcase
    end
  end

  // Count frame boundaries seen while still discarding post-reset frames.
  always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      skip_cnt <= '0;
    end else if (state == ST_SKIP && vs_rise && skip_cnt != 16'(FRAME_SKIP)) begin
      skip_cnt <= skip_cnt + 16'd1;
    end
  end

  // Pixel and line position within the captured frame, both saturating.
  always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      x <= '0;
      y <= '0;
    end else begin
      if (start_now || href_fall) begin
        x <= '0;
      end else if (complete) begin
        x <= sat_inc(x);
      end
      if (start_now) begin
        y <= '0;
      end else if (href_fall && in_capture) begin
        y <= sat_inc(y);
      end
    end
  end

  // Registered pixel output, frame pulses, completed-frame count and the sticky partial-pixel flag.
  always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ov5640_wr_en    <= 1'b0;
      ov5640_data_out <= '0;
      frame_start     <= 1'b0;
      frame_done      <= 1'b0;
      frame_cnt       <= '0;
      byte_err        <= 1'b0;
    end else begin
      ov5640_wr_en <= pix_write;
      if (pix_write) begin
        ov5640_data_out <= pixel;
      end
      frame_start <= start_now;
      frame_done  <= done_now;
      if (done_now) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (href_fall && phase_nz) begin
        byte_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dvp_capture.sv
// Self-checking bench for dvp_capture: three instances (plain, byte-swapped, cropped) share one stimulus stream.
module tb_dvp_capture;

  typedef struct packed {
    logic [1:0]  dut;
    logic [15:0] pix;
  } pix_rec_t;

  typedef struct {
    logic        href;
    logic [7:0]  data;
    logic        exp_wr;
    bit          chk_dout;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic cap_en;
  logic vsync;
  logic href;
  logic [7:0] data;

  logic        wr   [3];
  logic [15:0] dout [3];
  logic        fs   [3];
  logic        fd   [3];
  logic [15:0] fcnt [3];
  logic        berr [3];

  int total = 0;
  int bad = 0;

  // Reference model state, kept at frame/pixel level.
  int          rise_cnt;
  bit          capturing;
  logic [15:0] m_frame_cnt;
  int          m_starts = 0;
  int          m_dones = 0;
  bit          m_byte_err;
  int          line_idx;

  pix_rec_t exp_q[$];
  pix_rec_t act_q[$];
  int n_starts [3] = '{0, 0, 0};
  int n_dones  [3] = '{0, 0, 0};

  vec_t vecs [6];

  always #5 clk = ~clk;

  dvp_capture #(.DATA_W(8), .PIX_BYTES(2), .BYTE_SWAP(1'b0), .FRAME_SKIP(2),
                .H_START(12'd0), .H_SIZE(12'd4), .V_START(12'd0), .V_SIZE(12'd2)) dut_a (
    .ov5640_pclk(clk), .sys_rst_n(rst_n), .cap_en(cap_en), .ov5640_vsync(vsync),
    .ov5640_href(href), .ov5640_data(data), .ov5640_wr_en(wr[0]), .ov5640_data_out(dout[0]),
    .frame_start(fs[0]), .frame_done(fd[0]), .frame_cnt(fcnt[0]), .byte_err(berr[0]));

  dvp_capture #(.DATA_W(8), .PIX_BYTES(2), .BYTE_SWAP(1'b1), .FRAME_SKIP(2),
                .H_START(12'd0), .H_SIZE(12'd4), .V_START(12'd0), .V_SIZE(12'd2)) dut_b (
    .ov5640_pclk(clk), .sys_rst_n(rst_n), .cap_en(cap_en), .ov5640_vsync(vsync),
    .ov5640_href(href), .ov5640_data(data), .ov5640_wr_en(wr[1]), .ov5640_data_out(dout[1]),
    .frame_start(fs[1]), .frame_done(fd[1]), .frame_cnt(fcnt[1]), .byte_err(berr[1]));

  dvp_capture #(.DATA_W(8), .PIX_BYTES(2), .BYTE_SWAP(1'b0), .FRAME_SKIP(2),
                .H_START(12'd1), .H_SIZE(12'd2), .V_START(12'd1), .V_SIZE(12'd1)) dut_c (
    .ov5640_pclk(clk), .sys_rst_n(rst_n), .cap_en(cap_en), .ov5640_vsync(vsync),
    .ov5640_href(href), .ov5640_data(data), .ov5640_wr_en(wr[2]), .ov5640_data_out(dout[2]),
    .frame_start(fs[2]), .frame_done(fd[2]), .frame_cnt(fcnt[2]), .byte_err(berr[2]));

  // Record every written pixel and every frame pulse, sampled away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (wr[i]) act_q.push_back('{dut: 2'(i), pix: dout[i]});
      if (fs[i]) n_starts[i]++;
      if (fd[i]) n_dones[i]++;
    end
  end

  // Bound the whole run in case the stimulus ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit in_win(input int i, input int x, input int y);
    case (i)
      2:       return (x >= 1) && (x < 3) && (y == 1);
      default: return (x < 4) && (y < 2);
    endcase
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    rise_cnt    = 0;
    capturing   = 1'b0;
    m_frame_cnt = '0;
    m_byte_err  = 1'b0;
    line_idx    = 0;
  endtask

  task automatic check_reset(input string tag);
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("%s wr_en dut%0d", tag, i), 32'(wr[i]), 32'd0);
      check_val($sformatf("%s data_out dut%0d", tag, i), 32'(dout[i]), 32'd0);
      check_val($sformatf("%s frame_start dut%0d", tag, i), 32'(fs[i]), 32'd0);
      check_val($sformatf("%s frame_done dut%0d", tag, i), 32'(fd[i]), 32'd0);
      check_val($sformatf("%s frame_cnt dut%0d", tag, i), 32'(fcnt[i]), 32'd0);
      check_val($sformatf("%s byte_err dut%0d", tag, i), 32'(berr[i]), 32'd0);
    end
  endtask

  // Frame boundary: update the model from the frame rules at the moment vsync rises.
  task automatic vs_pulse();
    @(negedge clk);
    vsync = 1'b1;
    rise_cnt++;
    if (capturing) begin
      m_dones++;
      m_frame_cnt++;
    end
    capturing = (rise_cnt > 2) && cap_en;
    if (capturing) m_starts++;
    line_idx = 0;
    repeat (2) @(negedge clk);
    vsync = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // One line of n random beats followed by a short blanking gap.
  task automatic drive_line(input int n);
    logic [7:0] first;
    first = '0;
    for (int b = 0; b < n; b++) begin
      @(negedge clk);
      href = 1'b1;
      data = 8'($urandom);
      if (b % 2 == 0) begin
        first = data;
      end else if (capturing) begin
        for (int i = 0; i < 3; i++) begin
          if (in_win(i, b / 2, line_idx))
            exp_q.push_back('{dut: 2'(i), pix: (i == 1) ? {data, first} : {first, data}});
        end
      end
    end
    @(negedge clk);
    href = 1'b0;
    data = '0;
    if (capturing && (n % 2 == 1)) m_byte_err = 1'b1;
    line_idx++;
    repeat (2) @(negedge clk);
  endtask

  task automatic applyStimulus(input int nlines, input int nbytes);
    vs_pulse();
    for (int l = 0; l < nlines; l++) drive_line(nbytes);
  endtask

  // Compare captured pixels, frame counters and the error flag against the model.
  task automatic checkOutput(input string tag);
    logic [15:0] e[$];
    logic [15:0] a[$];
    for (int i = 0; i < 3; i++) begin
      e.delete();
      a.delete();
      foreach (exp_q[k]) if (exp_q[k].dut == 2'(i)) e.push_back(exp_q[k].pix);
      foreach (act_q[k]) if (act_q[k].dut == 2'(i)) a.push_back(act_q[k].pix);
      check_val($sformatf("%s pix_count dut%0d", tag, i), 32'(a.size()), 32'(e.size()));
      for (int k = 0; k < e.size() && k < a.size(); k++)
        check_val($sformatf("%s pix%0d dut%0d", tag, k, i), 32'(a[k]), 32'(e[k]));
      check_val($sformatf("%s frame_cnt dut%0d", tag, i), 32'(fcnt[i]), 32'(m_frame_cnt));
      check_val($sformatf("%s starts dut%0d", tag, i), 32'(n_starts[i]), 32'(m_starts));
      check_val($sformatf("%s dones dut%0d", tag, i), 32'(n_dones[i]), 32'(m_dones));
      check_val($sformatf("%s byte_err dut%0d", tag, i), 32'(berr[i]), 32'(m_byte_err));
    end
    exp_q.delete();
    act_q.delete();
  endtask

  initial begin
    int nl;
    int nb;

    rst_n  = 1'b0;
    cap_en = 1'b0;
    vsync  = 1'b0;
    href   = 1'b0;
    data   = '0;
    model_reset();

    vecs[0] = '{1'b1, 8'hAB, 1'b0, 1'b0, 16'h0000, 16'h0000};
    vecs[1] = '{1'b1, 8'hCD, 1'b1, 1'b1, 16'hABCD, 16'hCDAB};
    vecs[2] = '{1'b1, 8'h12, 1'b0, 1'b1, 16'hABCD, 16'hCDAB};
    vecs[3] = '{1'b1, 8'h34, 1'b1, 1'b1, 16'h1234, 16'h3412};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 16'h1234, 16'h3412};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 16'h1234, 16'h3412};

    repeat (3) @(negedge clk);
    check_reset("por");
    @(negedge clk);
    rst_n  = 1'b1;
    cap_en = 1'b1;

    // Two skipped frames, then the first captured one.
    for (int f = 0; f < 3; f++) begin
      applyStimulus(2, 8);
      checkOutput($sformatf("skip_f%0d", f));
    end

    // Fourth frame: three lines, exercises the crop window on dut_c.
    applyStimulus(3, 8);
    checkOutput("crop");

    // Cycle-exact packing and wr_en timing.
    vs_pulse();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      href = vecs[k].href;
      data = vecs[k].data;
      @(posedge clk);
      #1;
      check_val($sformatf("vec%0d wr_en a", k), 32'(wr[0]), 32'(vecs[k].exp_wr));
      check_val($sformatf("vec%0d wr_en b", k), 32'(wr[1]), 32'(vecs[k].exp_wr));
      if (vecs[k].chk_dout) begin
        check_val($sformatf("vec%0d data_out a", k), 32'(dout[0]), 32'(vecs[k].exp_a));
        check_val($sformatf("vec%0d data_out b", k), 32'(dout[1]), 32'(vecs[k].exp_b));
      end
    end
    repeat (2) @(negedge clk);
    act_q.delete();
    exp_q.delete();

    // Partial pixel at the end of a line, then a clean frame with the flag still set.
    vs_pulse();
    drive_line(7);
    drive_line(8);
    checkOutput("partial");
    applyStimulus(2, 8);
    checkOutput("clean_after_partial");

    // cap_en dropped mid-frame: frame completes, then idle until re-enabled and a new vsync.
    vs_pulse();
    drive_line(8);
    cap_en = 1'b0;
    drive_line(8);
    checkOutput("drop_mid");
    vs_pulse();
    drive_line(8);
    checkOutput("idle_after_drop");
    cap_en = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("enable_no_vs");
    applyStimulus(1, 8);
    checkOutput("reenable");

    // Randomized frames.
    for (int f = 0; f < 8; f++) begin
      cap_en = 1'($urandom_range(0, 1));
      nl = int'($urandom_range(1, 3));
      nb = int'($urandom_range(1, 10));
      applyStimulus(nl, nb);
      checkOutput($sformatf("rand_f%0d", f));
    end

    // Reset asserted in the middle of a line, right after a pixel write.
    cap_en = 1'b1;
    vs_pulse();
    drive_line(8);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      href = 1'b1;
      data = 8'($urandom);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("mid_line");
    @(negedge clk);
    href = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("mid_line_hold");
    model_reset();
    exp_q.delete();
    act_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    for (int f = 0; f < 3; f++) begin
      applyStimulus(2, 8);
      checkOutput($sformatf("post_reset_f%0d", f));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
